// File: rtl/hs32_wb_master_pkg.sv
// Shared definitions for the hs32 Wishbone classic initiator: FSM encodings,
// the all-bytes select value and the default bus-cycle timeout.
package hs32_wb_master_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [3:0] SEL_ALL         = 4'hF;
    localparam int         TMO_CYC_DEFAULT = 255;

endpackage

// File: rtl/hs32_wbm_watchdog.sv
// Bus-cycle watchdog: down-counter loaded on request accept, decremented while
// the bus cycle is open; expired flags the last permitted bus cycle.
module hs32_wbm_watchdog
    import hs32_wb_master_pkg::*;
#(
    parameter int TMO_CYC = TMO_CYC_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int            CW   = (TMO_CYC > 255) ? $clog2(TMO_CYC + 1) : 8;
    localparam logic [CW-1:0] LOAD = CW'(TMO_CYC - 1);

    logic [CW-1:0] count;

    // Loading TMO_CYC-1 makes the terminal count coincide with the
    // TMO_CYC-th bus cycle, so termination lands on that cycle's closing edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= LOAD;
        end else if (en && (count != '0)) begin
            count <= count - CW'(1);
        end
    end

    assign expired = en && (count == '0);

endmodule

// File: rtl/hs32_wb_master.sv
// Wishbone B4 classic single-transfer initiator with valid/ready request and response channels.
// Optional bus-cycle timeout enabled by defining HS32_WBM_TIMEOUT_EN.
module hs32_wb_master
    import hs32_wb_master_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TMO_CYC = TMO_CYC_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    input  logic [3:0]    req_wstrb,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_rdata,
    output logic          rsp_err,
    output logic          wbm_cyc_o,
    output logic          wbm_stb_o,
    output logic          wbm_we_o,
    output logic [3:0]    wbm_sel_o,
    output logic [AW-1:0] wbm_adr_o,
    output logic [DW-1:0] wbm_dat_o,
    input  logic [DW-1:0] wbm_dat_i,
    input  logic          wbm_ack_i,
    input  logic          wbm_err_i,
    output logic          busy
);

    if ((DW != 32) || (TMO_CYC < 1)) begin : g_bad_cfg
        $error("hs32_wb_master: DW must be 32 and TMO_CYC at least 1");
    end

    state_t state, state_nxt;
    logic   accept;
    logic   expired;
    logic   term_err;
    logic   term;

    assign accept = (state == ST_IDLE) && req_valid;

`ifdef HS32_WBM_TIMEOUT_EN
    hs32_wbm_watchdog #(
        .TMO_CYC (TMO_CYC)
    ) u_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (accept),
        .en      (state == ST_BUS),
        .expired (expired)
    );
`else
    assign expired = 1'b0;
`endif

    // A slave ack on the timeout edge still counts as a good transfer.
    assign term_err = wbm_err_i || (expired && !wbm_ack_i);
    assign term     = wbm_ack_i || term_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        busy      = 1'b1;
        unique case (state)
            ST_IDLE: begin
                req_ready = rst_n;
                busy      = 1'b0;
                if (req_valid) begin
                    state_nxt = ST_BUS;
                end
            end
            ST_BUS: begin
                if (term) begin
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Bus outputs are registered; adr/dat keep their last value between cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wbm_cyc_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            wbm_sel_o <= '0;
            wbm_adr_o <= '0;
            wbm_dat_o <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        wbm_cyc_o <= 1'b1;
                        wbm_we_o  <= req_we;
                        wbm_sel_o <= req_we ? req_wstrb : SEL_ALL;
                        wbm_adr_o <= req_addr;
                        wbm_dat_o <= req_wdata;
                    end
                end
                ST_BUS: begin
                    if (term) begin
                        wbm_cyc_o <= 1'b0;
                        wbm_we_o  <= 1'b0;
                        wbm_sel_o <= '0;
                        rsp_err   <= term_err;
                        rsp_rdata <= (term_err || wbm_we_o) ? '0 : wbm_dat_i;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign wbm_stb_o = wbm_cyc_o;

endmodule

// File: tb/tb_hs32_wb_master.sv
// Self-checking bench for hs32_wb_master with a behavioural Wishbone slave
// (combinational-ack, registered-ack or silent) and randomized transfers.
module tb_hs32_wb_master;

`ifdef HS32_WBM_TIMEOUT_EN
    localparam int TMO = 4;
`else
    localparam int TMO = 255;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_wstrb = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o, wbm_dat_o;
    logic [31:0] wbm_dat_i;
    logic        wbm_ack_i, wbm_err_i;
    logic        busy;

    int vectors = 0;
    int errors  = 0;

    // slave model: mode 0 silent, 1 ack in the same cycle as stb, 2 ack one cycle later
    int          slv_mode = 0;
    logic        slv_err = 1'b0;
    logic        slv_both = 1'b0;
    logic [31:0] slv_rdata = '0;
    logic        stray_ack = 1'b0;
    logic        stray_err = 1'b0;
    logic        term_r;
    logic        slv_term;

    always #5 clk = ~clk;

    hs32_wb_master #(.AW(32), .DW(32), .TMO_CYC(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o), .wbm_sel_o(wbm_sel_o),
        .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_dat_i(wbm_dat_i),
        .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i), .busy(busy)
    );

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) term_r <= 1'b0;
        else        term_r <= (slv_mode == 2) && wbm_cyc_o && !term_r;
    end

    always_comb begin
        slv_term  = (slv_mode == 1) ? wbm_cyc_o : ((slv_mode == 2) ? term_r : 1'b0);
        wbm_err_i = (slv_term && slv_err) || stray_err;
        wbm_ack_i = (slv_term && (!slv_err || slv_both)) || stray_ack;
        wbm_dat_i = slv_term ? slv_rdata : 32'hDEAD_BEEF;
    end

    // Caller sits at a negedge; returns at the negedge after the response is consumed.
    // t counts negedges after the accept edge (t=0 is the first cycle with stb high).
    task automatic run_xfer(
        input  logic we, input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
        input  int mode, input logic err, input logic both, input logic [31:0] rd,
        input  int hold, input logic keep_valid,
        output int lat, output int ncyc, output logic [3:0] o_sel, output logic o_we,
        output logic [31:0] o_adr, output logic [31:0] o_dat, output logic [31:0] o_rdata,
        output logic o_err, output logic proto_ok, output logic held_off);
        int guard;
        lat = -1; ncyc = 0; proto_ok = 1'b1; held_off = 1'b1;
        o_sel = 'x; o_we = 'x; o_adr = 'x; o_dat = 'x; o_rdata = 'x; o_err = 'x;
        slv_mode = mode; slv_err = err; slv_both = both; slv_rdata = rd;
        req_we = we; req_addr = addr; req_wdata = wdata; req_wstrb = wstrb; req_valid = 1'b1;
        rsp_ready = 1'b0;
        guard = 0;
        while (req_ready !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        if (!keep_valid) begin
            req_valid = 1'b0;
            req_we = 1'($urandom); req_addr = $urandom; req_wdata = $urandom; req_wstrb = 4'($urandom);
        end
        for (int t = 0; t < 60 && lat < 0; t++) begin
            if (t > 0) @(negedge clk);
            if (req_ready !== 1'b0) held_off = 1'b0;
            if (wbm_stb_o !== wbm_cyc_o) proto_ok = 1'b0;
            if (wbm_cyc_o === 1'b1) begin
                if (ncyc == 0) begin
                    o_sel = wbm_sel_o; o_we = wbm_we_o; o_adr = wbm_adr_o; o_dat = wbm_dat_o;
                end else if (wbm_sel_o !== o_sel || wbm_we_o !== o_we ||
                             wbm_adr_o !== o_adr || wbm_dat_o !== o_dat) begin
                    proto_ok = 1'b0;
                end
                ncyc++;
            end
            if (rsp_valid === 1'b1) begin
                lat = t; o_rdata = rsp_rdata; o_err = rsp_err;
            end
        end
        if (lat < 0) return;
        repeat (hold) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_rdata !== o_rdata || rsp_err !== o_err) proto_ok = 1'b0;
            if (req_ready !== 1'b0) held_off = 1'b0;
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) proto_ok = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        vectors++;
        if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || busy !== 1'b0 || wbm_cyc_o !== 1'b0 ||
            wbm_stb_o !== 1'b0 || wbm_we_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got rdy=%b rv=%b busy=%b cyc=%b stb=%b we=%b, expected all 0",
                     req_ready, rsp_valid, busy, wbm_cyc_o, wbm_stb_o, wbm_we_o);
        end
        vectors++;
        if (wbm_sel_o !== 4'h0 || wbm_adr_o !== 32'h0 || wbm_dat_o !== 32'h0 ||
            rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_data: got sel=%h adr=%h dat=%h rdata=%h err=%b, expected all 0",
                     wbm_sel_o, wbm_adr_o, wbm_dat_o, rsp_rdata, rsp_err);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (req_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got rdy=%b busy=%b, expected rdy=1 busy=0", req_ready, busy);
        end
    endtask

    task automatic test_read();
        int lat, ncyc; logic [3:0] sel; logic we, err, ok, ho; logic [31:0] adr, dat, rdata;
        run_xfer(1'b0, 32'h3000_0000, 32'h0, 4'h0, 2, 1'b0, 1'b0, 32'h1234_5678, 0, 1'b0,
                 lat, ncyc, sel, we, adr, dat, rdata, err, ok, ho);
        vectors++;
        if (lat !== 2 || ncyc !== 2) begin
            errors++; $display("FAIL read_timing: got lat=%0d cyc=%0d, expected lat=2 cyc=2", lat, ncyc);
        end
        vectors++;
        if (sel !== 4'hF || we !== 1'b0 || adr !== 32'h3000_0000) begin
            errors++; $display("FAIL read_bus: got sel=%h we=%b adr=%h, expected F 0 30000000", sel, we, adr);
        end
        vectors++;
        if (rdata !== 32'h1234_5678 || err !== 1'b0 || ok !== 1'b1) begin
            errors++; $display("FAIL read_rsp: got rdata=%h err=%b ok=%b, expected 12345678 0 1", rdata, err, ok);
        end
        vectors++;
        if (wbm_adr_o !== 32'h3000_0000 || wbm_sel_o !== 4'h0 || wbm_cyc_o !== 1'b0) begin
            errors++; $display("FAIL read_idle_bus: got adr=%h sel=%h cyc=%b, expected 30000000 0 0",
                               wbm_adr_o, wbm_sel_o, wbm_cyc_o);
        end
    endtask

    task automatic test_write();
        int lat, ncyc; logic [3:0] sel; logic we, err, ok, ho; logic [31:0] adr, dat, rdata;
        run_xfer(1'b1, 32'h3000_0004, 32'hA5A5_0000, 4'b1100, 1, 1'b0, 1'b0, 32'hFFFF_FFFF, 1, 1'b0,
                 lat, ncyc, sel, we, adr, dat, rdata, err, ok, ho);
        vectors++;
        if (sel !== 4'b1100 || dat !== 32'hA5A5_0000 || we !== 1'b1 || adr !== 32'h3000_0004) begin
            errors++; $display("FAIL write_bus: got sel=%h dat=%h we=%b adr=%h, expected C A5A50000 1 30000004",
                               sel, dat, we, adr);
        end
        vectors++;
        if (rdata !== 32'h0 || err !== 1'b0 || lat !== 1 || ncyc !== 1 || ok !== 1'b1) begin
            errors++; $display("FAIL write_rsp: got rdata=%h err=%b lat=%0d cyc=%0d ok=%b, expected 0 0 1 1 1",
                               rdata, err, lat, ncyc, ok);
        end
    endtask

    task automatic test_err_ack();
        int lat, ncyc; logic [3:0] sel; logic we, err, ok, ho; logic [31:0] adr, dat, rdata;
        run_xfer(1'b0, 32'h3000_0008, 32'h0, 4'h0, 1, 1'b1, 1'b1, 32'h7777_7777, 0, 1'b0,
                 lat, ncyc, sel, we, adr, dat, rdata, err, ok, ho);
        vectors++;
        if (err !== 1'b1 || rdata !== 32'h0) begin
            errors++; $display("FAIL err_ack_rsp: got err=%b rdata=%h, expected 1 0", err, rdata);
        end
        vectors++;
        if (ncyc !== 1 || lat !== 1) begin
            errors++; $display("FAIL err_ack_timing: got cyc=%0d lat=%0d, expected 1 1", ncyc, lat);
        end
    endtask

    task automatic test_backpressure();
        int lat, ncyc; logic [3:0] sel; logic we, err, ok, ho; logic [31:0] adr, dat, rdata;
        run_xfer(1'b0, 32'h3000_0010, 32'h0, 4'h0, 2, 1'b0, 1'b0, 32'hCAFE_F00D, 5, 1'b1,
                 lat, ncyc, sel, we, adr, dat, rdata, err, ok, ho);
        vectors++;
        if (ho !== 1'b1 || ok !== 1'b1 || rdata !== 32'hCAFE_F00D || err !== 1'b0) begin
            errors++; $display("FAIL backpressure_hold: got held_off=%b ok=%b rdata=%h err=%b, expected 1 1 cafef00d 0",
                               ho, ok, rdata, err);
        end
        run_xfer(1'b1, 32'h3000_0014, 32'h0BAD_CAFE, 4'b0011, 1, 1'b0, 1'b0, 32'h1, 0, 1'b0,
                 lat, ncyc, sel, we, adr, dat, rdata, err, ok, ho);
        vectors++;
        if (adr !== 32'h3000_0014 || dat !== 32'h0BAD_CAFE || sel !== 4'b0011 || lat !== 1) begin
            errors++; $display("FAIL backpressure_second: got adr=%h dat=%h sel=%h lat=%0d, expected 30000014 0badcafe 3 1",
                               adr, dat, sel, lat);
        end
    endtask

    task automatic test_stray();
        int bad = 0;
        stray_ack = 1'b1; stray_err = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (busy !== 1'b0 || rsp_valid !== 1'b0 || wbm_cyc_o !== 1'b0) bad++;
        end
        stray_ack = 1'b0; stray_err = 1'b0;
        vectors++;
        if (bad != 0) begin
            errors++; $display("FAIL stray_ack_idle: got %0d disturbed cycles, expected 0", bad);
        end
    endtask

    task automatic test_random();
        int lat, ncyc, mode, hold, exp_lat; logic [3:0] sel, wstrb, exp_sel;
        logic we, err, ok, ho, r_we, r_err, r_both; logic [31:0] adr, dat, rdata, addr, wdata, rd, exp_rd;
        for (int i = 0; i < 24; i++) begin
            r_we = 1'($urandom); addr = $urandom; wdata = $urandom; wstrb = 4'($urandom);
            mode = 1 + int'($urandom_range(1)); r_err = ($urandom_range(3) == 0);
            r_both = 1'($urandom); rd = $urandom; hold = int'($urandom_range(3));
            run_xfer(r_we, addr, wdata, wstrb, mode, r_err, r_both, rd, hold, 1'b0,
                     lat, ncyc, sel, we, adr, dat, rdata, err, ok, ho);
            exp_sel = r_we ? wstrb : 4'hF;
            exp_rd  = (r_we || r_err) ? 32'h0 : rd;
            exp_lat = (mode == 1) ? 1 : 2;
            vectors++;
            if (sel !== exp_sel || we !== r_we || adr !== addr || (r_we && dat !== wdata)) begin
                errors++; $display("FAIL rand_bus[%0d]: got sel=%h we=%b adr=%h dat=%h, expected %h %b %h %h",
                                   i, sel, we, adr, dat, exp_sel, r_we, addr, wdata);
            end
            vectors++;
            if (rdata !== exp_rd || err !== r_err) begin
                errors++; $display("FAIL rand_rsp[%0d]: got rdata=%h err=%b, expected %h %b", i, rdata, err, exp_rd, r_err);
            end
            vectors++;
            if (lat !== exp_lat || ncyc !== exp_lat || ok !== 1'b1 || ho !== 1'b1) begin
                errors++; $display("FAIL rand_proto[%0d]: got lat=%0d cyc=%0d ok=%b held=%b, expected lat=cyc=%0d ok=1 held=1",
                                   i, lat, ncyc, ok, ho, exp_lat);
            end
        end
    endtask

    task automatic test_timeout();
`ifdef HS32_WBM_TIMEOUT_EN
        int lat, ncyc; logic [3:0] sel; logic we, err, ok, ho; logic [31:0] adr, dat, rdata;
        run_xfer(1'b0, 32'h3000_0020, 32'h0, 4'h0, 0, 1'b0, 1'b0, 32'h5555_5555, 0, 1'b0,
                 lat, ncyc, sel, we, adr, dat, rdata, err, ok, ho);
        vectors++;
        if (ncyc !== TMO || lat !== TMO) begin
            errors++; $display("FAIL timeout_timing: got cyc=%0d lat=%0d, expected %0d %0d", ncyc, lat, TMO, TMO);
        end
        vectors++;
        if (err !== 1'b1 || rdata !== 32'h0) begin
            errors++; $display("FAIL timeout_rsp: got err=%b rdata=%h, expected 1 0", err, rdata);
        end
`else
        slv_mode = 0;
        req_we = 1'b0; req_addr = 32'h3000_0020; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (1000) @(negedge clk);
        vectors++;
        if (wbm_cyc_o !== 1'b1 || busy !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++; $display("FAIL no_timeout_wait: got cyc=%b busy=%b rv=%b, expected 1 1 0",
                               wbm_cyc_o, busy, rsp_valid);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
`endif
    endtask

    task automatic test_reset_midcycle();
        int guard = 0;
        int bad = 0;
        slv_mode = 0;
        req_we = 1'b0; req_addr = 32'h3000_0030; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        while (wbm_stb_o !== 1'b1 && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        vectors++;
        if (wbm_stb_o !== 1'b1) begin
            errors++; $display("FAIL rst_mid_setup: got stb=%b, expected 1", wbm_stb_o);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if (wbm_cyc_o !== 1'b0 || wbm_stb_o !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b0) begin
            errors++; $display("FAIL rst_mid_async: got cyc=%b stb=%b busy=%b rdy=%b, expected 0 0 0 0",
                               wbm_cyc_o, wbm_stb_o, busy, req_ready);
        end
        slv_mode = 1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) bad++;
        end
        vectors++;
        if (bad != 0) begin
            errors++; $display("FAIL rst_mid_release: got %0d bad idle cycles, expected 0", bad);
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_err_ack();
        test_backpressure();
        test_stray();
        test_random();
        test_timeout();
        test_reset_midcycle();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no completion, expected finish before 2000000");
        $fatal(1);
    end

endmodule
